// File: rtl/ct_calendar.sv
// rtl/ct_calendar.sv - day counter with month/date/day-of-year/year decode and validated load
// Advances one day per en pulse; doy is kept as its own counter alongside month/date.
module ct_calendar #(
   parameter int YEAR_W    = 12,
   parameter int YEAR_INIT = 2000,
   parameter bit LEAP_EN   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              ld,
   input  logic [YEAR_W-1:0] ld_year,
   input  logic [3:0]        ld_month,
   input  logic [4:0]        ld_date,
   output logic [YEAR_W-1:0] year,
   output logic [3:0]        month,
   output logic [4:0]        date,
   output logic [8:0]        doy,
   output logic              leap,
   output logic              z,
   output logic              ld_err
);

   // Year is widened first so the /100 and /400 tests stay correct for narrow YEAR_W.
   function automatic logic f_is_leap(input logic [YEAR_W-1:0] y);
      logic [31:0] v;
      v = 32'(y);
      if (!LEAP_EN)
         return 1'b0;
      return (v[1:0] == 2'd0) && (((v % 32'd100) != 32'd0) || ((v % 32'd400) == 32'd0));
   endfunction

   function automatic logic [4:0] f_dim(input logic [3:0] m, input logic lp);
      case (m)
         4'd2:                      return 5'd28 + {4'd0, lp};
         4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
         default:                   return 5'd31;
      endcase
   endfunction

   function automatic logic [8:0] f_cum(input logic [3:0] m, input logic lp);
      logic [8:0] c;
      case (m)
         4'd2:    c = 9'd31;
         4'd3:    c = 9'd59;
         4'd4:    c = 9'd90;
         4'd5:    c = 9'd120;
         4'd6:    c = 9'd151;
         4'd7:    c = 9'd181;
         4'd8:    c = 9'd212;
         4'd9:    c = 9'd243;
         4'd10:   c = 9'd273;
         4'd11:   c = 9'd304;
         4'd12:   c = 9'd334;
         default: c = 9'd0;
      endcase
      if (m > 4'd2)
         c = c + {8'd0, lp};
      return c;
   endfunction

   logic [YEAR_W-1:0] r_year;
   logic [3:0]        r_month;
   logic [4:0]        r_date;
   logic [8:0]        r_doy;
   logic              r_leap;
   logic              r_ld_err;

   logic              w_ld_leap;
   logic              w_ld_ok;
   logic [4:0]        w_dim;
   logic [YEAR_W-1:0] w_year_inc;
   logic              w_inc_leap;
   logic [8:0]        w_ld_doy;

   assign w_ld_leap  = f_is_leap(ld_year);
   assign w_ld_ok    = (ld_month >= 4'd1) && (ld_month <= 4'd12) &&
                       (ld_date >= 5'd1) && (ld_date <= f_dim(ld_month, w_ld_leap));
   assign w_ld_doy   = f_cum(ld_month, w_ld_leap) + {4'd0, ld_date} - 9'd1;
   assign w_dim      = f_dim(r_month, r_leap);
   assign w_year_inc = r_year + YEAR_W'(1);
   assign w_inc_leap = f_is_leap(w_year_inc);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_year   <= YEAR_W'(YEAR_INIT);
         r_month  <= 4'd1;
         r_date   <= 5'd1;
         r_doy    <= 9'd0;
         r_leap   <= f_is_leap(YEAR_W'(YEAR_INIT));
         r_ld_err <= 1'b0;
      end else if (ld) begin
         // A load owns the edge; a coincident en is dropped even when the load is rejected.
         if (w_ld_ok) begin
            r_year   <= ld_year;
            r_month  <= ld_month;
            r_date   <= ld_date;
            r_doy    <= w_ld_doy;
            r_leap   <= w_ld_leap;
            r_ld_err <= 1'b0;
         end else begin
            r_ld_err <= 1'b1;
         end
      end else begin
         r_ld_err <= 1'b0;
         if (en) begin
            if (r_date < w_dim) begin
               r_date <= r_date + 5'd1;
               r_doy  <= r_doy + 9'd1;
            end else if (r_month < 4'd12) begin
               r_month <= r_month + 4'd1;
               r_date  <= 5'd1;
               r_doy   <= r_doy + 9'd1;
            end else begin
               r_month <= 4'd1;
               r_date  <= 5'd1;
               r_doy   <= 9'd0;
               r_year  <= w_year_inc;
               r_leap  <= w_inc_leap;
            end
         end
      end
   end

   assign year   = r_year;
   assign month  = r_month;
   assign date   = r_date;
   assign doy    = r_doy;
   assign leap   = r_leap;
   assign ld_err = r_ld_err;
   assign z      = (r_month == 4'd12) && (r_date == 5'd31);

endmodule

// File: tb/tb_ct_calendar.sv
// tb/tb_ct_calendar.sv - scoreboard bench for ct_calendar
// Three instances (default, 4-bit year, no leap rule) share stimulus; each expectation names its instance.
module tb_ct_calendar;

   typedef struct packed {
      logic [11:0] year;
      logic [3:0]  month;
      logic [4:0]  date;
      logic [8:0]  doy;
      logic        leap;
      logic        z;
      logic        ld_err;
   } st_t;

   typedef struct {
      int    sel;
      int    due;
      st_t   exp;
      string name;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        ld = 1'b0;
   logic [11:0] ld_year = '0;
   logic [3:0]  ld_month = '0;
   logic [4:0]  ld_date = '0;

   logic [11:0] y0;
   logic [3:0]  m0, m1, m2;
   logic [4:0]  d0, d1, d2;
   logic [8:0]  doy0, doy1, doy2;
   logic        lp0, lp1, lp2, z0, z1, z2, e0, e1, e2;
   logic [3:0]  y1;
   logic [11:0] y2;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   ent_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ct_calendar #(.YEAR_W(12), .YEAR_INIT(2000), .LEAP_EN(1'b1)) u_main (
      .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_year(ld_year), .ld_month(ld_month), .ld_date(ld_date),
      .year(y0), .month(m0), .date(d0), .doy(doy0), .leap(lp0), .z(z0), .ld_err(e0));

   ct_calendar #(.YEAR_W(4), .YEAR_INIT(0), .LEAP_EN(1'b1)) u_small (
      .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_year(ld_year[3:0]), .ld_month(ld_month), .ld_date(ld_date),
      .year(y1), .month(m1), .date(d1), .doy(doy1), .leap(lp1), .z(z1), .ld_err(e1));

   ct_calendar #(.YEAR_W(12), .YEAR_INIT(2000), .LEAP_EN(1'b0)) u_noleap (
      .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_year(ld_year), .ld_month(ld_month), .ld_date(ld_date),
      .year(y2), .month(m2), .date(d2), .doy(doy2), .leap(lp2), .z(z2), .ld_err(e2));

   function automatic st_t mk(input int y, input int m, input int d, input int dy,
                              input bit lp, input bit zz, input bit er);
      st_t s;
      s.year = 12'(y); s.month = 4'(m); s.date = 5'(d); s.doy = 9'(dy);
      s.leap = lp; s.z = zz; s.ld_err = er;
      return s;
   endfunction

   function automatic st_t actual(input int sel);
      if (sel == 1) return {8'd0, y1, m1, d1, doy1, lp1, z1, e1};
      if (sel == 2) return {y2, m2, d2, doy2, lp2, z2, e2};
      return {y0, m0, d0, doy0, lp0, z0, e0};
   endfunction

   task automatic drive(input bit r, input bit e, input bit l,
                        input int y, input int m, input int d);
      @(posedge clk);
      #1;
      rst = r; en = e; ld = l;
      ld_year = 12'(y); ld_month = 4'(m); ld_date = 5'(d);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic run_en(input int n);
      repeat (n) drive(0, 1, 0, 0, 0, 0);
   endtask

   // Expectation for the state seen after the edge that samples the inputs just driven.
   task automatic expect_st(input int sel, input string name, input st_t s);
      ent_t e;
      e.sel = sel; e.due = cyc + 1; e.exp = s; e.name = name;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         ent_t e;
         st_t  a;
         e = sb.pop_front();
         a = actual(e.sel);
         checks++;
         if (e.due != cyc) begin
            errors++;
            $display("FAIL %s: sampled late at cycle %0d, due %0d", e.name, cyc, e.due);
         end else if (a !== e.exp) begin
            errors++;
            $display("FAIL %s: got y=%0d m=%0d d=%0d doy=%0d leap=%0b z=%0b err=%0b, exp y=%0d m=%0d d=%0d doy=%0d leap=%0b z=%0b err=%0b",
                     e.name, a.year, a.month, a.date, a.doy, a.leap, a.z, a.ld_err,
                     e.exp.year, e.exp.month, e.exp.date, e.exp.doy, e.exp.leap, e.exp.z, e.exp.ld_err);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, %0d checks pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1, 0, 0, 0, 0, 0);
      expect_st(0, "reset", mk(2000, 1, 1, 0, 1, 0, 0));
      expect_st(1, "reset_small", mk(0, 1, 1, 0, 1, 0, 0));
      expect_st(2, "reset_noleap", mk(2000, 1, 1, 0, 0, 0, 0));

      run_en(31);  expect_st(0, "en31", mk(2000, 2, 1, 31, 1, 0, 0));
      run_en(28);  expect_st(0, "en59", mk(2000, 2, 29, 59, 1, 0, 0));
      run_en(1);   expect_st(0, "en60", mk(2000, 3, 1, 60, 1, 0, 0));
      run_en(305); expect_st(0, "en365_dec31", mk(2000, 12, 31, 365, 1, 1, 0));
      idle();      expect_st(0, "z_hold_no_en", mk(2000, 12, 31, 365, 1, 1, 0));
      run_en(1);   expect_st(0, "en366_rollover", mk(2001, 1, 1, 0, 0, 0, 0));

      drive(0, 0, 1, 1900, 2, 28); expect_st(0, "ld_1900_0228", mk(1900, 2, 28, 58, 0, 0, 0));
      run_en(1);                   expect_st(0, "1900_en", mk(1900, 3, 1, 59, 0, 0, 0));
      drive(0, 0, 1, 2000, 2, 29); expect_st(0, "ld_2000_0229", mk(2000, 2, 29, 59, 1, 0, 0));
      drive(0, 0, 1, 2023, 12, 31); expect_st(0, "ld_2023_1231", mk(2023, 12, 31, 364, 0, 1, 0));
      run_en(1);                   expect_st(0, "2023_rollover", mk(2024, 1, 1, 0, 1, 0, 0));

      drive(0, 0, 1, 2023, 2, 29); expect_st(0, "ld_bad_feb29", mk(2024, 1, 1, 0, 1, 0, 1));
      idle();                      expect_st(0, "err_pulse_end", mk(2024, 1, 1, 0, 1, 0, 0));
      drive(0, 0, 1, 2024, 13, 1); expect_st(0, "ld_month13", mk(2024, 1, 1, 0, 1, 0, 1));
      drive(0, 0, 1, 2024, 5, 0);  expect_st(0, "ld_date0", mk(2024, 1, 1, 0, 1, 0, 1));
      drive(0, 0, 1, 2024, 0, 5);  expect_st(0, "ld_month0", mk(2024, 1, 1, 0, 1, 0, 1));
      idle();                      expect_st(0, "err_clear", mk(2024, 1, 1, 0, 1, 0, 0));

      drive(0, 1, 1, 2020, 7, 4);  expect_st(0, "ld_with_en", mk(2020, 7, 4, 185, 1, 0, 0));
      drive(0, 1, 1, 2021, 4, 31); expect_st(0, "bad_ld_with_en", mk(2020, 7, 4, 185, 1, 0, 1));
      run_en(1);                   expect_st(0, "en_after_bad", mk(2020, 7, 5, 186, 1, 0, 0));
      drive(1, 1, 1, 2020, 7, 4);  expect_st(0, "rst_over_ld_en", mk(2000, 1, 1, 0, 1, 0, 0));

      drive(0, 0, 1, 15, 12, 31);  expect_st(1, "small_ld_15", mk(15, 12, 31, 364, 0, 1, 0));
      run_en(1);                   expect_st(1, "small_wrap", mk(0, 1, 1, 0, 1, 0, 0));

      drive(1, 0, 0, 0, 0, 0);     expect_st(2, "noleap_reset", mk(2000, 1, 1, 0, 0, 0, 0));
      run_en(58);                  expect_st(2, "noleap_feb28", mk(2000, 2, 28, 58, 0, 0, 0));
      run_en(1);                   expect_st(2, "noleap_skip29", mk(2000, 3, 1, 59, 0, 0, 0));
      run_en(305);                 expect_st(2, "noleap_dec31", mk(2000, 12, 31, 364, 0, 1, 0));
      run_en(1);                   expect_st(2, "noleap_rollover", mk(2001, 1, 1, 0, 0, 0, 0));
      drive(0, 0, 1, 2000, 2, 29); expect_st(2, "noleap_ld_feb29", mk(2001, 1, 1, 0, 0, 0, 1));

      repeat (3) idle();
      if (sb.size() != 0) begin
         errors += sb.size();
         $display("FAIL drain: %0d expectations never checked, exp 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
